// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end.
// Optional HALT detection in the fetch stage is enabled by IF_HALT_DETECT_EN.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_STEP     = 4;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;
  localparam int          OPC_MSB     = 31;
  localparam int          OPC_LSB     = 26;

  function automatic logic is_halt(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: synchronous load port,
// combinational fetch port.
module instruction_memory #(
  parameter  int SIZE      = 32,
  parameter  int MEM_DEPTH = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [SIZE-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [SIZE-1:0]   rdata
);

  logic [SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write to the fetched word is forwarded to the read.
  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC select and IF/ID latch.
// Build with IF_HALT_DETECT_EN to stop fetching at a HALT opcode.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int              SIZE      = 32,
  parameter int              MEM_DEPTH = 256,
  parameter int              ADDR_W    = $clog2(MEM_DEPTH),
  parameter logic [SIZE-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_jump,
  input  logic [SIZE-1:0]   i_jump_target,
  input  logic              i_branch_taken,
  input  logic [SIZE-1:0]   i_branch_target,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [SIZE-1:0]   i_load_data,
  output logic [SIZE-1:0]   o_instruction,
  output logic [SIZE-1:0]   o_pc_plus4,
  output logic [SIZE-1:0]   o_pc,
  output logic              o_valid,
  output logic              o_halted
);

  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic [SIZE-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [SIZE-1:0] pc_plus4;
  logic [SIZE-1:0] fetch_word;
  logic            unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^{i_jump_target[1:0], i_branch_target[1:0]};

  instruction_memory #(
    .SIZE      (SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (i_load_en),
    .waddr (i_load_addr),
    .wdata (i_load_data),
    .raddr (pc_q[ADDR_W+1:2]),
    .rdata (fetch_word)
  );

  assign pc_plus4 = pc_q + SIZE'(PC_STEP);

`ifdef IF_HALT_DETECT_EN
  logic halted_q, halted_d;
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef IF_HALT_DETECT_EN
    halted_d = halted_q;
`endif
    if (i_load_en) begin
      pc_d    = RESET_PC;
      instr_d = SIZE'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
`ifdef IF_HALT_DETECT_EN
      halted_d = 1'b0;
    end else if (halted_q) begin
      instr_d = SIZE'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
`endif
    end else if (i_jump) begin
      pc_d    = {i_jump_target[SIZE-1:2], 2'b00};
      instr_d = SIZE'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (i_branch_taken) begin
      pc_d    = {i_branch_target[SIZE-1:2], 2'b00};
      instr_d = SIZE'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (i_stall) begin
      pc_d = pc_q;
    end else if (i_flush) begin
      pc_d    = pc_plus4;
      instr_d = SIZE'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
`ifdef IF_HALT_DETECT_EN
      // HALT itself is delivered; the PC parks on it.
      if (is_halt(fetch_word)) begin
        pc_d     = pc_q;
        halted_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= SIZE'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
  assign o_halted = halted_q;
`else
  assign o_halted = 1'b0;
`endif

  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_pc_plus4    = pc4_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch (vector table + scoreboard).
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_target = '0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        i_load_en = 1'b0;
  logic [7:0]  i_load_addr = '0;
  logic [31:0] i_load_data = '0;
  logic [31:0] o_instruction;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_halted;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_load_en       (i_load_en),
    .i_load_addr     (i_load_addr),
    .i_load_data     (i_load_data),
    .o_instruction   (o_instruction),
    .o_pc_plus4      (o_pc_plus4),
    .o_pc            (o_pc),
    .o_valid         (o_valid),
    .o_halted        (o_halted)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
  } exp_t;

  vec_t vt[19];
  exp_t sb[$];

  function automatic logic [31:0] memval(input int i);
    case (i)
      0:       return 32'h2001_0005;
      1:       return 32'h2002_0003;
      2, 3:    return 32'h0000_0000;
      default: return 32'h2400_0000 | 32'(i);
    endcase
  endfunction

  function automatic vec_t mk(
    input logic s, input logic f,
    input logic j, input logic [31:0] jt,
    input logic b, input logic [31:0] bt,
    input logic [31:0] pc, input logic [31:0] ins,
    input logic [31:0] p4, input logic v);
    vec_t r;
    r.stall = s; r.flush = f; r.jump = j; r.jt = jt;
    r.br = b; r.bt = bt; r.pc = pc; r.ins = ins;
    r.p4 = p4; r.v = v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_stall = 0; i_flush = 0; i_jump = 0;
    i_branch_taken = 0; i_load_en = 0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    i_load_en   = 1'b1;
    i_load_addr = 8'(a);
    i_load_data = d;
    step();
  endtask

  initial begin
    exp_t e;
    vt[0]  = mk(0,0,0,0,0,0, 32'h04, memval(0),  32'h04, 1);
    vt[1]  = mk(0,0,0,0,0,0, 32'h08, memval(1),  32'h08, 1);
    vt[2]  = mk(1,0,0,0,0,0, 32'h08, memval(1),  32'h08, 1);
    vt[3]  = mk(1,0,0,0,0,0, 32'h08, memval(1),  32'h08, 1);
    vt[4]  = mk(1,0,0,0,0,0, 32'h08, memval(1),  32'h08, 1);
    vt[5]  = mk(0,0,0,0,0,0, 32'h0C, memval(2),  32'h0C, 1);
    vt[6]  = mk(0,0,0,0,0,0, 32'h10, memval(3),  32'h10, 1);
    vt[7]  = mk(1,0,0,0,1,32'h43, 32'h40, 0, 0, 0);
    vt[8]  = mk(0,0,0,0,0,0, 32'h44, memval(16), 32'h44, 1);
    vt[9]  = mk(0,0,1,32'h20,1,32'h80, 32'h20, 0, 0, 0);
    vt[10] = mk(0,0,0,0,0,0, 32'h24, memval(8),  32'h24, 1);
    vt[11] = mk(0,1,0,0,0,0, 32'h28, 0, 0, 0);
    vt[12] = mk(1,1,0,0,0,0, 32'h28, 0, 0, 0);
    vt[13] = mk(0,0,0,0,0,0, 32'h2C, memval(10), 32'h2C, 1);
    vt[14] = mk(0,0,1,32'h3FF,0,0, 32'h3FC, 0, 0, 0);
    vt[15] = mk(0,0,0,0,0,0, 32'h400, memval(255), 32'h400, 1);
    vt[16] = mk(0,0,0,0,0,0, 32'h404, memval(0),   32'h404, 1);
    vt[17] = mk(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 0, 0, 0);
    vt[18] = mk(0,0,0,0,0,0, 32'h0, memval(255), 32'h0, 1);

    #2 rst = 1'b0;
    #1;
    chk("reset_pc",    o_pc, 32'h0);
    chk("reset_instr", o_instruction, 32'h0);
    chk("reset_pc4",   o_pc_plus4, 32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_halt",  32'(o_halted), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 256; i++) begin
      load_word(i, memval(i));
      if (i == 5) begin
        chk("load_pc",    o_pc, 32'h0);
        chk("load_valid", 32'(o_valid), 32'h0);
      end
    end
    idle();

    for (int i = 0; i < 19; i++) begin
      i_stall         = vt[i].stall;
      i_flush         = vt[i].flush;
      i_jump          = vt[i].jump;
      i_jump_target   = vt[i].jt;
      i_branch_taken  = vt[i].br;
      i_branch_target = vt[i].bt;
      e.idx = i; e.pc = vt[i].pc; e.ins = vt[i].ins;
      e.p4 = vt[i].p4; e.v = vt[i].v;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'h1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pc", e.idx),    o_pc, e.pc);
        chk($sformatf("v%0d_instr", e.idx), o_instruction, e.ins);
        chk($sformatf("v%0d_pc4", e.idx),   o_pc_plus4, e.p4);
        chk($sformatf("v%0d_valid", e.idx), 32'(o_valid), 32'(e.v));
        chk($sformatf("v%0d_halt", e.idx),  32'(o_halted), 32'h0);
      end
    end
    idle();

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b0;
    #1;
    chk("arst_pc",    o_pc, 32'h0);
    chk("arst_instr", o_instruction, 32'h0);
    chk("arst_pc4",   o_pc_plus4, 32'h0);
    chk("arst_valid", 32'(o_valid), 32'h0);
    #1 rst = 1'b1;
    step();
    chk("post_rst_pc",    o_pc, 32'h4);
    chk("post_rst_instr", o_instruction, memval(0));
    chk("post_rst_valid", 32'(o_valid), 32'h1);

    load_word(2, 32'hFC00_0000);
    idle();
    step();
    step();
    step();
`ifdef IF_HALT_DETECT_EN
    chk("halt_instr", o_instruction, 32'hFC00_0000);
    chk("halt_valid", 32'(o_valid), 32'h1);
    chk("halt_pc",    o_pc, 32'h8);
    chk("halt_flag",  32'(o_halted), 32'h1);
    step();
    chk("halt_nop",   o_instruction, 32'h0);
    chk("halt_nopv",  32'(o_valid), 32'h0);
    chk("halt_pc2",   o_pc, 32'h8);
    i_jump = 1'b1; i_jump_target = 32'h20;
    step();
    idle();
    chk("halt_jump_pc", o_pc, 32'h8);
    chk("halt_sticky",  32'(o_halted), 32'h1);
    load_word(2, 32'h0);
    idle();
    chk("halt_clear",   32'(o_halted), 32'h0);
    chk("halt_clr_pc",  o_pc, 32'h0);
`else
    chk("ff_instr", o_instruction, 32'hFC00_0000);
    chk("ff_pc",    o_pc, 32'h0C);
    chk("ff_valid", 32'(o_valid), 32'h1);
    chk("ff_halt",  32'(o_halted), 32'h0);
    step();
    chk("ff_next",  o_instruction, memval(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline; directly upstream of instruction decode.
- Holds the PC and a loadable instruction memory.
- Registers the IF/ID pipeline latch (instruction, PC+4, valid) that decode consumes.
- Handles stall, flush, and jump/branch redirection from later stages.

Parameters:
- SIZE, 32, data/instruction/PC width
- MEM_DEPTH, 256, instruction memory depth in words
- ADDR_W, $clog2(MEM_DEPTH), word-index width
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_stall  input  1  hold PC and IF/ID (hazard unit)
- i_flush  input  1  load a NOP bubble into IF/ID
- i_jump  input  1  jump redirect request
- i_jump_target  input  SIZE  jump destination byte address
- i_branch_taken  input  1  taken-branch redirect request
- i_branch_target  input  SIZE  branch destination byte address
- i_load_en  input  1  program-load mode; write instruction memory
- i_load_addr  input  ADDR_W  word index to write
- i_load_data  input  SIZE  instruction word to write
- o_instruction  output  SIZE  IF/ID instruction
- o_pc_plus4  output  SIZE  IF/ID PC+4
- o_pc  output  SIZE  current fetch PC (unregistered view of the PC register)
- o_valid  output  1  IF/ID holds a real fetched instruction
- o_halted  output  1  HALT seen (feature only; otherwise tied 0)

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC, o_instruction=0 (NOP), o_pc_plus4=0, o_valid=0, o_halted=0.
  - Memory contents are not cleared.
- Reset deasserted mid-program: the next fetch starts at RESET_PC; there is no partial state.
- Instruction memory:
  - Write is synchronous when i_load_en=1.
  - Read is combinational at index PC[ADDR_W+1:2].
  - PC bits above the index are ignored, so addresses wrap modulo MEM_DEPTH words.
- Per-edge priority, highest first:
  1. i_load_en: PC←RESET_PC; IF/ID←NOP, valid=0.
  2. i_jump: PC←{i_jump_target[SIZE-1:2],2'b00}; IF/ID←NOP, valid=0.
  3. i_branch_taken: PC←{i_branch_target[SIZE-1:2],2'b00}; IF/ID←NOP, valid=0.
  4. i_stall: PC and IF/ID both hold.
  5. i_flush: PC←PC+4; IF/ID←NOP, valid=0.
  6. Normal: PC←PC+4; IF/ID←{mem[PC], PC+4}, valid=1.
- Jump and branch in the same cycle: jump wins.
- Redirect wins over stall: the bubble is inserted and stall is ignored for that edge.
- Stall together with flush: stall wins. Decode keeps its stalled instruction; the flush is re-presented by the control unit.
- PC+4 wraps at 2^SIZE with no flag.
- Misaligned targets have bits [1:0] forced to 0.
- Latency: an instruction at address A appears on o_instruction one edge after PC==A with no stall.
- Branch/jump penalty: one bubble.
- Load during a fetch: a write to the index currently addressed is visible to that cycle's combinational read. This is irrelevant in practice because load mode bubbles IF/ID.

Optional Feature:
- Macro: IF_HALT_DETECT_EN
- Defined:
  - When the word being latched into IF/ID has opcode [31:26]==6'b111111, it is latched with valid=1.
  - On that edge the PC freezes at the HALT address and o_halted←1 (sticky).
  - Subsequent edges latch NOP with valid=0.
  - Only reset or i_load_en clears o_halted.
  - Redirects are ignored while halted.
- Undefined: o_halted is tied 0 and opcode 6'b111111 is fetched like any other word.

Decomposition:
- Package mips_pkg holds:
  - NOP_INSTR=32'h0000_0000
  - PC_STEP=4
  - HALT_OPCODE=6'b111111
  - OPCODE field bounds (31:26)
- Sub-module instruction_memory (SIZE, MEM_DEPTH): synchronous write, combinational read. The PC register, next-PC mux and IF/ID latch stay in the top.

Test Plan:
- Reset, then load mem[0..3]=32'h2001_0005, 32'h2002_0003, 32'h0000_0000, 32'h0000_0000, deassert i_load_en → o_instruction=32'h2001_0005 / o_pc_plus4=4 on edge 1, then 32'h2002_0003 / 8 on edge 2; valid=1.
- i_stall held 3 cycles at PC=8 → o_pc stays 8, o_instruction/o_pc_plus4 unchanged, valid unchanged; release → PC=12 next edge.
- i_branch_taken=1, target=32'h0000_0043, same cycle as i_stall=1 → PC=32'h40, IF/ID=NOP, valid=0; next edge fetches mem[16].
- i_jump=1 target=0x20 together with i_branch_taken=1 target=0x80 → PC=0x20.
- PC at 4*(MEM_DEPTH-1), MEM_DEPTH=256 → next fetch PC=0x400 reads mem[0] (wrap); assert rst low mid-run → async clear of all outputs before the next edge.
- IF_HALT_DETECT_EN: mem[2]=32'hFC00_0000 → o_halted=1 when that word is latched, PC frozen at 8, following IF/ID NOPs; jump request ignored; i_load_en clears o_halted.
